// File: rtl/attack_arbiter_pkg.sv
// Shared definitions for the attack arbiter: phase encoding, player coordinate
// width and the unsigned distance helper used by the hit range check.
package attack_arbiter_pkg;

  localparam int unsigned PLAYER_X_W = 10;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_WINDUP  = 2'd1,
    PH_ACTIVE  = 2'd2,
    PH_RECOVER = 2'd3
  } phase_t;

  // Larger minus smaller, widened by one bit so the result never wraps.
  function automatic logic [PLAYER_X_W:0] abs_dx(input logic [PLAYER_X_W-1:0] a,
                                                 input logic [PLAYER_X_W-1:0] b);
    logic [PLAYER_X_W:0] wa;
    logic [PLAYER_X_W:0] wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    return (wa >= wb) ? (wa - wb) : (wb - wa);
  endfunction

endpackage

// File: rtl/attack_arbiter_if.sv
// Bus between the controller/game-core side and the attack arbiter.
// The slave modport is the arbiter's view; master is the driving side.
interface attack_arbiter_if;
  import attack_arbiter_pkg::*;

  logic                  frame_tick;
  logic                  in_fight;
  logic                  p1_attack_req;
  logic                  p1_shield_req;
  logic                  p2_attack_req;
  logic                  p2_shield_req;
  logic [PLAYER_X_W-1:0] p1_x;
  logic [PLAYER_X_W-1:0] p2_x;
  logic                  p1_attack_grant;
  logic                  p2_attack_grant;
  logic                  p1_busy;
  logic                  p2_busy;
  logic                  hit_on_p2;
  logic                  hit_on_p1;
  logic                  block_by_p2;
  logic                  block_by_p1;

  modport master (
    output frame_tick, in_fight,
    output p1_attack_req, p1_shield_req, p2_attack_req, p2_shield_req,
    output p1_x, p2_x,
    input  p1_attack_grant, p2_attack_grant, p1_busy, p2_busy,
    input  hit_on_p2, hit_on_p1, block_by_p2, block_by_p1
  );

  modport slave (
    input  frame_tick, in_fight,
    input  p1_attack_req, p1_shield_req, p2_attack_req, p2_shield_req,
    input  p1_x, p2_x,
    output p1_attack_grant, p2_attack_grant, p1_busy, p2_busy,
    output hit_on_p2, hit_on_p1, block_by_p2, block_by_p1
  );

endinterface

// File: rtl/attack_arbiter_phase_fsm.sv
// Per-fighter attack sequencer: button edge capture, pending flag and the
// IDLE -> WINDUP -> ACTIVE -> RECOVER phase walk, paced by frame ticks.
module attack_phase_fsm
  import attack_arbiter_pkg::*;
#(
  parameter int unsigned WINDUP_FRAMES   = 3,
  parameter int unsigned ACTIVE_FRAMES   = 4,
  parameter int unsigned COOLDOWN_FRAMES = 10
) (
  input  logic   clk,
  input  logic   rst_l,
  input  logic   i_frame_tick,
  input  logic   i_in_fight,
  input  logic   i_attack_req,
  input  logic   i_shield_req,
  input  logic   i_land,
  output phase_t o_phase,
  output logic   o_busy,
  output logic   o_active,
  output logic   o_hit_done
);

  localparam logic [3:0] LP_WINDUP   = 4'(WINDUP_FRAMES);
  localparam logic [3:0] LP_ACTIVE   = 4'(ACTIVE_FRAMES);
  localparam logic [3:0] LP_COOLDOWN = 4'(COOLDOWN_FRAMES);

  phase_t     r_phase;
  phase_t     w_phase_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_pending;
  logic       w_pending_nxt;
  logic       r_hit_done;
  logic       w_hit_done_nxt;
  logic       r_req_q;
  logic       w_rise;
  logic       w_last;

  assign w_rise = i_attack_req & ~r_req_q;
  assign w_last = (r_cnt <= 4'd1);

  always_comb begin
    w_phase_nxt    = r_phase;
    w_cnt_nxt      = r_cnt;
    w_pending_nxt  = r_pending;
    w_hit_done_nxt = r_hit_done | i_land;
    if (!i_in_fight) begin
      w_phase_nxt    = PH_IDLE;
      w_cnt_nxt      = '0;
      w_pending_nxt  = 1'b0;
      w_hit_done_nxt = 1'b0;
    end else begin
      // Edges while shielding or mid-attack are dropped, never queued.
      if (w_rise && (r_phase == PH_IDLE) && !i_shield_req)
        w_pending_nxt = 1'b1;
      if (i_frame_tick) begin
        case (r_phase)
          PH_IDLE: begin
            if (r_pending) begin
              w_phase_nxt    = PH_WINDUP;
              w_cnt_nxt      = LP_WINDUP;
              w_pending_nxt  = 1'b0;
              w_hit_done_nxt = 1'b0;
            end
          end
          PH_WINDUP: begin
            if (w_last) begin
              w_phase_nxt = PH_ACTIVE;
              w_cnt_nxt   = LP_ACTIVE;
            end else begin
              w_cnt_nxt = r_cnt - 4'd1;
            end
          end
          PH_ACTIVE: begin
            if (w_last) begin
              w_phase_nxt = PH_RECOVER;
              w_cnt_nxt   = LP_COOLDOWN;
            end else begin
              w_cnt_nxt = r_cnt - 4'd1;
            end
          end
          PH_RECOVER: begin
            if (w_last) begin
              w_phase_nxt = PH_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt - 4'd1;
            end
          end
          default: w_phase_nxt = PH_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_phase    <= PH_IDLE;
      r_cnt      <= '0;
      r_pending  <= 1'b0;
      r_hit_done <= 1'b0;
      r_req_q    <= 1'b0;
    end else begin
      r_phase    <= w_phase_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pending  <= w_pending_nxt;
      r_hit_done <= w_hit_done_nxt;
      r_req_q    <= i_attack_req;
    end
  end

  assign o_phase    = r_phase;
  assign o_busy     = (r_phase != PH_IDLE);
  assign o_active   = (r_phase == PH_ACTIVE);
  assign o_hit_done = r_hit_done;

endmodule

// File: rtl/attack_arbiter.sv
// Two-fighter attack arbiter: sequences each player's attack and decides, on
// every frame tick, which ACTIVE attacker lands and whether it is blocked.
module attack_arbiter
  import attack_arbiter_pkg::*;
#(
  parameter int unsigned WINDUP_FRAMES   = 3,
  parameter int unsigned ACTIVE_FRAMES   = 4,
  parameter int unsigned COOLDOWN_FRAMES = 10,
  parameter int unsigned HIT_RANGE       = 60
) (
  input logic              clk,
  input logic              rst_l,
  attack_arbiter_if.slave  bus
);

  localparam logic [PLAYER_X_W:0] LP_RANGE = (PLAYER_X_W + 1)'(HIT_RANGE);

  phase_t              w_p1_phase;
  phase_t              w_p2_phase;
  logic                w_p1_busy;
  logic                w_p2_busy;
  logic                w_p1_active;
  logic                w_p2_active;
  logic                w_p1_hit_done;
  logic                w_p2_hit_done;
  logic [PLAYER_X_W:0] w_dx;
  logic                w_in_range;
  logic                w_eval;
  logic                w_p1_elig;
  logic                w_p2_elig;
  logic                w_p1_land;
  logic                w_p2_land;
  logic                w_trade;
  logic                r_prio;
  logic                r_hit_on_p2;
  logic                r_hit_on_p1;
  logic                r_block_by_p2;
  logic                r_block_by_p1;

  attack_phase_fsm #(
    .WINDUP_FRAMES  (WINDUP_FRAMES),
    .ACTIVE_FRAMES  (ACTIVE_FRAMES),
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
  ) u_p1_fsm (
    .clk         (clk),
    .rst_l       (rst_l),
    .i_frame_tick(bus.frame_tick),
    .i_in_fight  (bus.in_fight),
    .i_attack_req(bus.p1_attack_req),
    .i_shield_req(bus.p1_shield_req),
    .i_land      (w_p1_land),
    .o_phase     (w_p1_phase),
    .o_busy      (w_p1_busy),
    .o_active    (w_p1_active),
    .o_hit_done  (w_p1_hit_done)
  );

  attack_phase_fsm #(
    .WINDUP_FRAMES  (WINDUP_FRAMES),
    .ACTIVE_FRAMES  (ACTIVE_FRAMES),
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
  ) u_p2_fsm (
    .clk         (clk),
    .rst_l       (rst_l),
    .i_frame_tick(bus.frame_tick),
    .i_in_fight  (bus.in_fight),
    .i_attack_req(bus.p2_attack_req),
    .i_shield_req(bus.p2_shield_req),
    .i_land      (w_p2_land),
    .o_phase     (w_p2_phase),
    .o_busy      (w_p2_busy),
    .o_active    (w_p2_active),
    .o_hit_done  (w_p2_hit_done)
  );

  assign w_dx       = abs_dx(bus.p1_x, bus.p2_x);
  assign w_in_range = (w_dx <= LP_RANGE);
  assign w_eval     = bus.frame_tick & bus.in_fight;
  assign w_p1_elig  = w_p1_active & ~w_p1_hit_done & w_in_range;
  assign w_p2_elig  = w_p2_active & ~w_p2_hit_done & w_in_range;

  // On a trade only the prio player lands; the loser stays eligible for later ticks.
  assign w_trade    = w_eval & w_p1_elig & w_p2_elig;
  assign w_p1_land  = w_eval & w_p1_elig & (~w_p2_elig | ~r_prio);
  assign w_p2_land  = w_eval & w_p2_elig & (~w_p1_elig |  r_prio);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_prio        <= 1'b0;
      r_hit_on_p2   <= 1'b0;
      r_hit_on_p1   <= 1'b0;
      r_block_by_p2 <= 1'b0;
      r_block_by_p1 <= 1'b0;
    end else begin
      r_prio        <= r_prio ^ w_trade;
      r_hit_on_p2   <= w_p1_land & ~bus.p2_shield_req;
      r_block_by_p2 <= w_p1_land &  bus.p2_shield_req;
      r_hit_on_p1   <= w_p2_land & ~bus.p1_shield_req;
      r_block_by_p1 <= w_p2_land &  bus.p1_shield_req;
    end
  end

  assign bus.p1_attack_grant = (w_p1_phase == PH_ACTIVE);
  assign bus.p2_attack_grant = (w_p2_phase == PH_ACTIVE);
  assign bus.p1_busy         = w_p1_busy;
  assign bus.p2_busy         = w_p2_busy;
  assign bus.hit_on_p2       = r_hit_on_p2;
  assign bus.hit_on_p1       = r_hit_on_p1;
  assign bus.block_by_p2     = r_block_by_p2;
  assign bus.block_by_p1     = r_block_by_p1;

endmodule
